// File: rtl/wshb_arb_pkg.sv
// Shared types and constants for the 2:1 Wishbone SDRAM arbiter.
//   arb_state_t : grant FSM encoding (idle, owned by M0, owned by M1, watchdog abort)
//   CTI_*       : Wishbone cycle-type identifiers used by the masters
package wshb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    OWN_M0,
    OWN_M1,
    ABORT
  } arb_state_t;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

endpackage

// File: rtl/wshb_arb_watchdog.sv
// Stall watchdog for the arbiter's slave strobe.
//   sys_clk, sys_rst_n : clock, synchronous active-low reset
//   clr                : clear the count (termination seen or strobe idle)
//   run                : count this cycle (strobe outstanding)
//   expired            : count has reached TIMEOUT-1
// The counter saturates at its maximum value rather than wrapping.
module wshb_arb_watchdog #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic clr,
  input  logic run,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CntLast = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CntMax  = '1;

  logic [CW-1:0] cnt_q;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n || clr) begin
      cnt_q <= '0;
    end else if (run && (cnt_q != CntMax)) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign expired = (cnt_q >= CntLast);

endmodule

// File: rtl/wshb_arbiter_2to1.sv
// Two-master Wishbone arbiter in front of the single SDRAM slave port.
//   sys_clk, sys_rst_n        : clock, synchronous active-low reset
//   m0_* / m1_*               : master ports (M0 video reader, M1 pattern/frame writer)
//   s_*                       : slave port towards the SDRAM controller
//   gnt                       : current owner one-hot {M1,M0}, 00 when idle
// Whole cyc-framed cycles are granted, ownership round-robins under contention, and a
// strobe that waits too long for a termination is aborted with err to its owner.
module wshb_arbiter_2to1
  import wshb_arb_pkg::*;
#(
  parameter int unsigned DATA_BYTES = 4,
  parameter int unsigned ADR_W      = 32,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst_n,
  input  logic                    m0_cyc,
  input  logic                    m0_stb,
  input  logic                    m0_we,
  input  logic [ADR_W-1:0]        m0_adr,
  input  logic [8*DATA_BYTES-1:0] m0_dat_ms,
  input  logic [DATA_BYTES-1:0]   m0_sel,
  input  logic [2:0]              m0_cti,
  input  logic [1:0]              m0_bte,
  output logic [8*DATA_BYTES-1:0] m0_dat_sm,
  output logic                    m0_ack,
  output logic                    m0_err,
  output logic                    m0_rty,
  input  logic                    m1_cyc,
  input  logic                    m1_stb,
  input  logic                    m1_we,
  input  logic [ADR_W-1:0]        m1_adr,
  input  logic [8*DATA_BYTES-1:0] m1_dat_ms,
  input  logic [DATA_BYTES-1:0]   m1_sel,
  input  logic [2:0]              m1_cti,
  input  logic [1:0]              m1_bte,
  output logic [8*DATA_BYTES-1:0] m1_dat_sm,
  output logic                    m1_ack,
  output logic                    m1_err,
  output logic                    m1_rty,
  output logic                    s_cyc,
  output logic                    s_stb,
  output logic                    s_we,
  output logic [ADR_W-1:0]        s_adr,
  output logic [8*DATA_BYTES-1:0] s_dat_ms,
  output logic [DATA_BYTES-1:0]   s_sel,
  output logic [2:0]              s_cti,
  output logic [1:0]              s_bte,
  input  logic [8*DATA_BYTES-1:0] s_dat_sm,
  input  logic                    s_ack,
  input  logic                    s_err,
  input  logic                    s_rty,
  output logic [1:0]              gnt
);

  arb_state_t state_q, state_d;
  logic       last_q, last_d;               // last master served: 0 = M0, 1 = M1
  logic       abort_own_q, abort_own_d;     // owner of the cycle being aborted
  logic       abort_pulse_q, abort_pulse_d; // first ABORT cycle: err to owner

  logic active, own1, own_cyc, own_stb, term, wd_expired, expire;

  assign active  = (state_q == OWN_M0) || (state_q == OWN_M1);
  assign own1    = (state_q == OWN_M1) || ((state_q == ABORT) && abort_own_q);
  assign own_cyc = own1 ? m1_cyc : m0_cyc;
  assign own_stb = own1 ? m1_stb : m0_stb;
  assign term    = active && (s_ack || s_err || s_rty);
  assign expire  = wd_expired && s_stb && !term;

  wshb_arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .clr       (term || !s_stb),
    .run       (s_stb),
    .expired   (wd_expired)
  );

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q       <= IDLE;
      last_q        <= 1'b1;
      abort_own_q   <= 1'b0;
      abort_pulse_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      abort_own_q   <= abort_own_d;
      abort_pulse_q <= abort_pulse_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    last_d        = last_q;
    abort_own_d   = abort_own_q;
    abort_pulse_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (m0_cyc && (!m1_cyc || last_q)) begin
          state_d = OWN_M0;
        end else if (m1_cyc) begin
          state_d = OWN_M1;
        end
      end
      OWN_M0: begin
        if (!m0_cyc) begin
          // Release wins over expiry: an abandoned cycle gets no response.
          last_d  = 1'b0;
          state_d = m1_cyc ? OWN_M1 : IDLE;
        end else if (expire) begin
          state_d       = ABORT;
          abort_own_d   = 1'b0;
          abort_pulse_d = 1'b1;
        end
      end
      OWN_M1: begin
        if (!m1_cyc) begin
          last_d  = 1'b1;
          state_d = m0_cyc ? OWN_M0 : IDLE;
        end else if (expire) begin
          state_d       = ABORT;
          abort_own_d   = 1'b1;
          abort_pulse_d = 1'b1;
        end
      end
      ABORT: begin
        if (!own_cyc) begin
          last_d  = abort_own_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Slave-side mux: everything forced to zero unless a master owns the bus.
  always_comb begin
    s_cyc    = active && own_cyc;
    s_stb    = active && own_cyc && own_stb;
    s_we     = 1'b0;
    s_adr    = '0;
    s_dat_ms = '0;
    s_sel    = '0;
    s_cti    = CTI_CLASSIC;
    s_bte    = '0;
    if (active) begin
      s_we     = own1 ? m1_we     : m0_we;
      s_adr    = own1 ? m1_adr    : m0_adr;
      s_dat_ms = own1 ? m1_dat_ms : m0_dat_ms;
      s_sel    = own1 ? m1_sel    : m0_sel;
      s_cti    = own1 ? m1_cti    : m0_cti;
      s_bte    = own1 ? m1_bte    : m0_bte;
    end
  end

  // Terminations reach only the owner; in ABORT the slave is ignored and the owner sees a
  // single synthetic err.
  always_comb begin
    m0_ack = (state_q == OWN_M0) && s_ack;
    m0_rty = (state_q == OWN_M0) && s_rty;
    m0_err = ((state_q == OWN_M0) && s_err) ||
             ((state_q == ABORT) && abort_pulse_q && !abort_own_q);
    m1_ack = (state_q == OWN_M1) && s_ack;
    m1_rty = (state_q == OWN_M1) && s_rty;
    m1_err = ((state_q == OWN_M1) && s_err) ||
             ((state_q == ABORT) && abort_pulse_q && abort_own_q);
  end

  assign m0_dat_sm = s_dat_sm;
  assign m1_dat_sm = s_dat_sm;
  assign gnt       = {(state_q != IDLE) && own1, (state_q != IDLE) && !own1};

endmodule

// File: tb/tb_wshb_arbiter_2to1.sv
// Directed bench for wshb_arbiter_2to1 (TIMEOUT = 16). Masters are small burst models
// driven from the initial block; the slave acks every strobe while ack_en is set.
module tb_wshb_arbiter_2to1;
  import wshb_arb_pkg::*;

  logic sys_clk = 1'b0;
  logic sys_rst_n;
  always #5 sys_clk = ~sys_clk;

  // Master models
  logic        mcyc[2];
  logic        mstb[2];
  logic [31:0] madr[2];
  logic [2:0]  mcti[2];
  int          mbeats[2];

  logic        m0_cyc, m0_stb, m1_cyc, m1_stb;
  logic [31:0] m0_adr, m1_adr, m0_dat_sm, m1_dat_sm;
  logic [2:0]  m0_cti, m1_cti;
  logic        m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty;
  assign m0_cyc = mcyc[0];
  assign m0_stb = mstb[0];
  assign m0_adr = madr[0];
  assign m0_cti = mcti[0];
  assign m1_cyc = mcyc[1];
  assign m1_stb = mstb[1];
  assign m1_adr = madr[1];
  assign m1_cti = mcti[1];

  // Slave side
  logic        s_cyc, s_stb, s_we, s_ack, s_err, s_rty;
  logic [31:0] s_adr, s_dat_ms;
  logic [3:0]  s_sel;
  logic [2:0]  s_cti;
  logic [1:0]  s_bte, gnt;
  logic        ack_en, force_ack;
  logic [31:0] sdat;
  assign s_ack = (ack_en && s_stb) || force_ack;
  assign s_err = 1'b0;
  assign s_rty = 1'b0;

  wshb_arbiter_2to1 #(
    .DATA_BYTES (4),
    .ADR_W      (32),
    .TIMEOUT    (16)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .m0_cyc    (m0_cyc),
    .m0_stb    (m0_stb),
    .m0_we     (1'b0),
    .m0_adr    (m0_adr),
    .m0_dat_ms (32'h0000_0000),
    .m0_sel    (4'hF),
    .m0_cti    (m0_cti),
    .m0_bte    (2'b00),
    .m0_dat_sm (m0_dat_sm),
    .m0_ack    (m0_ack),
    .m0_err    (m0_err),
    .m0_rty    (m0_rty),
    .m1_cyc    (m1_cyc),
    .m1_stb    (m1_stb),
    .m1_we     (1'b1),
    .m1_adr    (m1_adr),
    .m1_dat_ms (32'h1111_2222),
    .m1_sel    (4'hF),
    .m1_cti    (m1_cti),
    .m1_bte    (2'b00),
    .m1_dat_sm (m1_dat_sm),
    .m1_ack    (m1_ack),
    .m1_err    (m1_err),
    .m1_rty    (m1_rty),
    .s_cyc     (s_cyc),
    .s_stb     (s_stb),
    .s_we      (s_we),
    .s_adr     (s_adr),
    .s_dat_ms  (s_dat_ms),
    .s_sel     (s_sel),
    .s_cti     (s_cti),
    .s_bte     (s_bte),
    .s_dat_sm  (sdat),
    .s_ack     (s_ack),
    .s_err     (s_err),
    .s_rty     (s_rty),
    .gnt       (gnt)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Values sampled at the falling edge of the most recent step
  logic [1:0] smp_gnt;
  logic       smp_scyc, smp_sstb;
  logic       smp_ack[2], smp_err[2];
  int         ack_cnt[2], err_cnt[2];
  bit         chk_adr;
  int         order[$], gaps[$];
  bit         have_prev;
  logic       prev_owner;
  int         idle_run;

  // One clock: sample at negedge, then advance the master models just after posedge.
  task automatic step();
    @(negedge sys_clk);
    smp_gnt    = gnt;
    smp_scyc   = s_cyc;
    smp_sstb   = s_stb;
    smp_ack[0] = m0_ack;
    smp_ack[1] = m1_ack;
    smp_err[0] = m0_err;
    smp_err[1] = m1_err;
    for (int i = 0; i < 2; i++) begin
      if (smp_ack[i]) ack_cnt[i]++;
      if (smp_err[i]) err_cnt[i]++;
    end
    if (chk_adr && s_cyc) begin
      check("t2_s_adr", s_adr, madr[0]);
      check("t2_s_cti", s_cti, mcti[0]);
    end
    if (s_cyc) begin
      if (!have_prev || (gnt[1] != prev_owner)) begin
        order.push_back(gnt[1] ? 1 : 0);
        if (have_prev) gaps.push_back(idle_run);
      end
      prev_owner = gnt[1];
      have_prev  = 1'b1;
      idle_run   = 0;
    end else begin
      idle_run++;
    end
    @(posedge sys_clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (mcyc[i] && smp_err[i]) begin
        mcyc[i] = 1'b0;
        mstb[i] = 1'b0;
      end else if (mcyc[i] && smp_ack[i]) begin
        mbeats[i]--;
        madr[i] = madr[i] + 32'd4;
        if (mbeats[i] == 0) begin
          mcyc[i] = 1'b0;
          mstb[i] = 1'b0;
        end else if (mbeats[i] == 1) begin
          mcti[i] = CTI_EOB;
        end
      end
    end
  endtask

  task automatic start_burst(input int i, input logic [31:0] a, input int n);
    mcyc[i]   = 1'b1;
    mstb[i]   = 1'b1;
    madr[i]   = a;
    mbeats[i] = n;
    mcti[i]   = (n == 1) ? CTI_EOB : CTI_INCR;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((mcyc[0] || mcyc[1] || smp_gnt != 2'b00) && n < 200) begin
      step();
      n++;
    end
    check({tag, "_drain_in_time"}, n < 200, 1'b1);
  endtask

  initial begin
    int a0, a1, e1, n, bad;
    sys_rst_n = 1'b0;
    ack_en    = 1'b1;
    force_ack = 1'b0;
    sdat      = 32'hDEAD_BEEF;
    chk_adr   = 1'b0;
    have_prev = 1'b0;
    idle_run  = 0;
    smp_gnt   = 2'b00;
    for (int i = 0; i < 2; i++) begin
      mcyc[i] = 1'b0; mstb[i] = 1'b0; madr[i] = '0; mcti[i] = CTI_CLASSIC;
      mbeats[i] = 0; ack_cnt[i] = 0; err_cnt[i] = 0;
    end

    // 1. Reset with both masters requesting
    start_burst(0, 32'h0, 1);
    start_burst(1, 32'h40, 1);
    repeat (3) begin
      step();
      check("t1_rst_gnt", smp_gnt, 2'b00);
      check("t1_rst_scyc", smp_scyc, 1'b0);
      check("t1_rst_ack0", smp_ack[0], 1'b0);
      check("t1_rst_ack1", smp_ack[1], 1'b0);
    end
    sys_rst_n = 1'b1;
    step();
    check("t1_rel_gnt_before_edge", smp_gnt, 2'b00);
    step();  // first edge with reset released has made the decision: M0 (last = M1)
    check("t1_rel_gnt", smp_gnt, 2'b01);
    check("t1_rel_ack0", smp_ack[0], 1'b1);
    drain("t1");

    // 3. Contention, two rounds: strict alternation with a one-cycle gap at handoff
    order.delete();
    gaps.delete();
    for (int r = 0; r < 2; r++) begin
      have_prev = 1'b0;
      a0 = ack_cnt[0];
      a1 = ack_cnt[1];
      start_burst(0, 32'h1000 + 32'(r * 256), 4);
      start_burst(1, 32'h2000, 4);
      drain("t3");
      check("t3_m0_acks", ack_cnt[0] - a0, 4);
      check("t3_m1_acks", ack_cnt[1] - a1, 4);
    end
    check("t3_order_len", order.size(), 4);
    for (int k = 0; k < 4; k++)
      check($sformatf("t3_order%0d", k), (k < order.size()) ? order[k] : 9, k % 2);
    check("t3_gap_len", gaps.size(), 2);
    for (int k = 0; k < 2; k++)
      check($sformatf("t3_gap%0d", k), (k < gaps.size()) ? gaps[k] : 9, 1);

    // 2. Solo M0 8-beat incrementing burst at 0x100
    a0 = ack_cnt[0];
    a1 = ack_cnt[1];
    chk_adr = 1'b1;
    start_burst(0, 32'h100, 8);
    repeat (3) step();
    check("t2_dat_fanout0", m0_dat_sm, 32'hDEAD_BEEF);
    check("t2_dat_fanout1", m1_dat_sm, 32'hDEAD_BEEF);
    repeat (7) step();
    check("t2_gnt_release_cycle", smp_gnt, 2'b01);
    check("t2_scyc_release_cycle", smp_scyc, 1'b0);
    step();
    check("t2_gnt_end", smp_gnt, 2'b00);
    check("t2_m0_acks", ack_cnt[0] - a0, 8);
    check("t2_m1_acks", ack_cnt[1] - a1, 0);
    check("t2_next_adr", madr[0], 32'h120);
    chk_adr = 1'b0;

    // 4. No preemption: M0 holds a 50-beat burst while M1 waits
    start_burst(0, 32'h200, 50);
    step();
    start_burst(1, 32'h300, 2);
    n = 0;
    bad = 0;
    while (mcyc[0] && n < 60) begin
      step();
      n++;
      if (smp_gnt != 2'b01 || smp_ack[1]) bad++;
    end
    check("t4_hold_len", n, 50);
    check("t4_preempt_cycles", bad, 0);
    step();
    check("t4_rel_gnt", smp_gnt, 2'b01);
    check("t4_rel_ack1", smp_ack[1], 1'b0);
    step();
    check("t4_m1_gnt", smp_gnt, 2'b10);
    check("t4_m1_ack", smp_ack[1], 1'b1);
    drain("t4");

    // 5. Watchdog: slave never answers M1
    ack_en = 1'b0;
    e1 = err_cnt[1];
    start_burst(1, 32'h400, 2);
    step();
    step();
    check("t5_first_stb", smp_sstb, 1'b1);
    bad = 0;
    repeat (15) begin
      step();
      if (smp_err[1] || !smp_sstb) bad++;
    end
    check("t5_wait_cycles", bad, 0);
    step();  // 16 cycles after the first strobe
    check("t5_err", smp_err[1], 1'b1);
    check("t5_abort_scyc", smp_scyc, 1'b0);
    check("t5_abort_ack1", smp_ack[1], 1'b0);
    check("t5_abort_gnt", smp_gnt, 2'b10);
    start_burst(0, 32'h500, 1);
    ack_en = 1'b1;
    step();
    check("t5_err_single", smp_err[1], 1'b0);
    check("t5_abort_hold_scyc", smp_scyc, 1'b0);
    check("t5_abort_m0_ack", smp_ack[0], 1'b0);
    step();
    check("t5_idle_gnt", smp_gnt, 2'b00);
    step();
    check("t5_m0_gnt", smp_gnt, 2'b01);
    check("t5_m0_ack", smp_ack[0], 1'b1);
    check("t5_err_count", err_cnt[1] - e1, 1);
    drain("t5");

    // 6. Reset in the middle of an 8-beat burst
    start_burst(0, 32'h600, 8);
    repeat (3) step();
    sys_rst_n = 1'b0;
    step();
    check("t6_beat3_scyc", smp_scyc, 1'b1);
    force_ack = 1'b1;
    repeat (2) begin
      step();
      check("t6_rst_scyc", smp_scyc, 1'b0);
      check("t6_rst_gnt", smp_gnt, 2'b00);
      check("t6_rst_ack0", smp_ack[0], 1'b0);
      check("t6_rst_ack1", smp_ack[1], 1'b0);
    end
    mcyc[0] = 1'b0;
    mstb[0] = 1'b0;
    force_ack = 1'b0;
    sys_rst_n = 1'b1;
    repeat (2) step();
    check("t6_after_gnt", smp_gnt, 2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
